// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI slave and the SPI master.
// Holds the controller state encodings, the CPOL/CPHA mode constants and a
// mode enum with helpers that split a mode number into its CPOL/CPHA bits.
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic CPOL_LOW   = 1'b0;
    localparam logic CPOL_HIGH  = 1'b1;
    localparam logic CPHA_LEAD  = 1'b0;
    localparam logic CPHA_TRAIL = 1'b1;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    function automatic logic mode_cpol(input spi_mode_e mode);
        logic [1:0] bits;
        bits = mode;
        return bits[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_e mode);
        logic [1:0] bits;
        bits = mode;
        return bits[0];
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Parallel-side handshake between the SPI slave and its host logic.
//   tx_data / tx_load   : word to return on MISO and its one-cycle load strobe
//   tx_ready            : TX buffer may be loaded (slave idle)
//   rx_data / rx_valid  : last complete received word and its update pulse
//   frame_err           : pulse when a frame was cut short by CS
// Modport slave is used by the SPI slave, master by the host side.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_err;

    modport slave (
        input  tx_data, tx_load,
        output tx_ready, rx_data, rx_valid, frame_err
    );

    modport master (
        output tx_data, tx_load,
        input  tx_ready, rx_data, rx_valid, frame_err
    );
endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//   i_clk  : destination clock
//   i_rst  : asynchronous active-low reset, both flops load RST_VAL
//   i_d    : asynchronous input
//   o_q    : synchronized output
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;
endmodule

// File: rtl/spi_slave.sv
// SPI slave, all modes (CPOL/CPHA parameters), MSB first, DATA_WIDTH bits.
// SCLK/CS/MOSI are synchronized into i_clk; SCLK must stay at least 4 i_clk
// periods in each half-period.
//   i_clk, i_rst    : system clock, asynchronous active-low reset
//   i_spi_clk       : SCLK
//   i_cs            : chip select, active low
//   i_mosi          : MOSI
//   o_miso          : MISO, high-Z while synchronized CS is high
//   bus             : parallel TX/RX handshake (spi_slave_if.slave)
//   o_spi_state     : current FSM state for debug
//
// state | meaning
// IDLE  | waiting for CS fall; TX buffer loadable
// SHIFT | frame in progress, sampling MOSI and shifting MISO
// DONE  | word delivered; SCLK ignored, MISO driven 0 until CS rises
module spi_slave
    import spi_pkg::*;
#(
    parameter int   DATA_WIDTH = 16,
    parameter logic CPOL       = CPOL_LOW,
    parameter logic CPHA       = CPHA_LEAD
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_clk,
    input  logic       i_cs,
    input  logic       i_mosi,
    output logic       o_miso,
    spi_slave_if.slave bus,
    output logic [1:0] o_spi_state
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    logic sclk_s, cs_s, mosi_s;

    spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_clk), .o_q(sclk_s)
    );
    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs), .o_q(cs_s)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi), .o_q(mosi_s)
    );

    logic [1:0]            state_q, state_d;
    logic                  sclk_prev_q, sclk_prev_d;
    logic                  cs_prev_q, cs_prev_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    // The CS synchronizer resets to 1, so a CS held low through reset would
    // look like a fresh fall. Frames are only accepted once the synchronizer
    // has flushed (prime_cnt down to 0) and CS has actually been seen high.
    logic [1:0]            prime_cnt_q, prime_cnt_d;
    logic                  armed_q, armed_d;

    logic lead_edge, trail_edge, sample_edge, cs_fall;

    always_comb begin
        lead_edge   = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
        trail_edge  = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        cs_fall     = !cs_s && cs_prev_q;

        state_d     = state_q;
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_buf_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        prime_cnt_d = (prime_cnt_q == 2'd0) ? 2'd0 : prime_cnt_q - 2'd1;
        armed_d     = armed_q | ((prime_cnt_q == 2'd0) && cs_s);

        case (state_q)
            ST_IDLE: begin
                if (bus.tx_load) begin
                    tx_buf_d = bus.tx_data;
                end
                if (cs_fall && armed_q) begin
                    state_d    = ST_SHIFT;
                    tx_shift_d = bus.tx_load ? bus.tx_data : tx_buf_q;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_FULL) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                    // CPHA=1 presents the MSB at entry, so its first leading
                    // edge must not shift; bit_cnt is still 0 only then.
                    if ((!CPHA && trail_edge) ||
                        (CPHA && lead_edge && (bit_cnt_q != '0))) begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    // A CS rise coinciding with the last sample still completes.
                    if (cs_s && (bit_cnt_d != CNT_FULL)) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            prime_cnt_q <= 2'd3;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            prime_cnt_q <= prime_cnt_d;
            armed_q     <= armed_d;
        end
    end

    assign o_miso = cs_s ? 1'bz :
                    ((state_q == ST_SHIFT) ? tx_shift_q[DATA_WIDTH-1] : 1'b0);

    assign bus.tx_ready  = (state_q == ST_IDLE);
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign o_spi_state   = state_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode (0..3), a master model that
// drives SCLK/CS/MOSI and captures MISO, a reference model of the TX buffer
// and an rx/err scoreboard checked by an independent monitor.
module tb_spi_slave;
    localparam int DW = 16;
    localparam int H  = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [3:0]  sclk;
    logic [3:0]  cs;
    logic        mosi;
    logic [15:0] tx_data;
    logic        tx_load;

    wire  [3:0]  miso_w;
    wire  [3:0]  rx_valid_w;
    wire  [3:0]  frame_err_w;
    wire  [3:0]  tx_ready_w;
    wire  [15:0] rx_data_w [4];
    wire  [1:0]  state_w [4];

    always #5 i_clk = ~i_clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.tx_data    = tx_data;
        assign bus.tx_load    = tx_load;
        assign rx_valid_w[m]  = bus.rx_valid;
        assign frame_err_w[m] = bus.frame_err;
        assign tx_ready_w[m]  = bus.tx_ready;
        assign rx_data_w[m]   = bus.rx_data;

        spi_slave #(.DATA_WIDTH(DW), .CPOL(1'(m / 2)), .CPHA(1'(m % 2))) dut (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_spi_clk  (sclk[m]),
            .i_cs       (cs[m]),
            .i_mosi     (mosi),
            .o_miso     (miso_w[m]),
            .bus        (bus),
            .o_spi_state(state_w[m])
        );
    end

    typedef struct {
        int          mode;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_rx [$];
    int          exp_err [$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] model_buf [4];
    logic [15:0] model_rx  [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx_valid / frame_err pulse must match the next expectation.
    always @(negedge i_clk) begin
        exp_t e;
        int   em;
        for (int m = 0; m < 4; m++) begin
            if (rx_valid_w[m]) begin
                tests++;
                if (exp_rx.size() == 0) begin
                    fails++;
                    $display("FAIL rx_valid unexpected: mode %0d data %0h", m, rx_data_w[m]);
                end else begin
                    e = exp_rx.pop_front();
                    if (e.mode != m || e.data !== rx_data_w[m]) begin
                        fails++;
                        $display("FAIL rx word: got mode %0d data %0h expected mode %0d data %0h",
                                 m, rx_data_w[m], e.mode, e.data);
                    end
                end
            end
            if (frame_err_w[m]) begin
                tests++;
                if (exp_err.size() == 0) begin
                    fails++;
                    $display("FAIL frame_err unexpected: mode %0d", m);
                end else begin
                    em = exp_err.pop_front();
                    if (em != m) begin
                        fails++;
                        $display("FAIL frame_err mode: got %0d expected %0d", m, em);
                    end
                end
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge i_clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge i_clk);
        tx_load = 1'b0;
        for (int k = 0; k < 4; k++) model_buf[k] = v;
    endtask

    // Master side of one frame. Returns the bits captured on MISO.
    task automatic spi_frame(input int m, input logic [15:0] word, input int nbits,
                             input bit load_fall, input logic [15:0] load_val,
                             input int mid_bit, input logic [15:0] mid_val,
                             input int extra, input bit cs_last, input bit hold_cs,
                             output logic [15:0] rxw);
        bit cpol, cpha;
        bit stopped;
        cpol    = (m / 2) != 0;
        cpha    = (m % 2) != 0;
        rxw     = '0;
        stopped = 1'b0;
        @(negedge i_clk);
        sclk[m] = cpol;
        cs[m]   = 1'b0;
        mosi    = cpha ? 1'b0 : word[15];
        wait_n(2);
        if (load_fall) begin
            tx_data = load_val;
            tx_load = 1'b1;
        end
        @(negedge i_clk);
        tx_load = 1'b0;
        wait_n(H);
        for (int i = 0; i < nbits && !stopped; i++) begin
            if (!cpha) rxw[15-i] = miso_w[m];
            else       mosi = word[15-i];
            sclk[m] = ~cpol;
            if (!cpha && cs_last && i == nbits - 1) begin
                cs[m]   = 1'b1;
                stopped = 1'b1;
            end else begin
                wait_n(H);
                if (cpha) rxw[15-i] = miso_w[m];
                sclk[m] = cpol;
                if (!cpha && i < 15) mosi = word[14-i];
                if (cpha && cs_last && i == nbits - 1) begin
                    cs[m]   = 1'b1;
                    stopped = 1'b1;
                end else if (i == mid_bit) begin
                    tx_data = mid_val;
                    tx_load = 1'b1;
                    @(negedge i_clk);
                    tx_load = 1'b0;
                    wait_n(H - 1);
                end else begin
                    wait_n(H);
                end
            end
        end
        if (stopped) begin
            wait_n(H);
            sclk[m] = cpol;
        end
        for (int e = 0; e < extra; e++) begin
            sclk[m] = ~cpol;
            wait_n(H);
            check("done miso", {31'd0, miso_w[m]}, 32'd0);
            check("done state", {30'd0, state_w[m]}, 32'd2);
            sclk[m] = cpol;
            wait_n(H);
        end
        if (!hold_cs) begin
            cs[m] = 1'b1;
            wait_n(3 * H);
        end
    endtask

    // Full frame with reference-model expectations.
    task automatic run_frame(input int m, input logic [15:0] word, input bit lf,
                             input logic [15:0] lv, input int mid_bit, input logic [15:0] mv,
                             input int extra, input bit cs_last, input string tag);
        logic [15:0] exp_tx, got;
        exp_t        e;
        exp_tx = lf ? lv : model_buf[m];
        e.mode = m;
        e.data = word;
        exp_rx.push_back(e);
        model_rx[m] = word;
        spi_frame(m, word, 16, lf, lv, mid_bit, mv, extra, cs_last, 1'b0, got);
        if (lf) for (int k = 0; k < 4; k++) model_buf[k] = lv;
        if (mid_bit >= 0) for (int k = 0; k < 4; k++) if (k != m) model_buf[k] = mv;
        check({tag, " miso word"}, {16'd0, got}, {16'd0, exp_tx});
        check({tag, " back idle"}, {29'd0, tx_ready_w[m], state_w[m]}, 32'd4);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        logic [15:0] dummy;
        sclk    = 4'b1100;
        cs      = 4'hF;
        mosi    = 1'b0;
        tx_data = '0;
        tx_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            model_buf[k] = '0;
            model_rx[k]  = '0;
        end

        wait_n(3);
        check("reset state", {30'd0, state_w[0]}, 32'd0);
        check("reset rx_data", {16'd0, rx_data_w[0]}, 32'd0);
        check("reset pulses", {28'd0, rx_valid_w | frame_err_w}, 32'd0);
        check("reset tx_ready", {28'd0, tx_ready_w}, 32'hF);
        i_rst = 1'b1;
        wait_n(6);

        do_load(16'hA5C3);
        run_frame(0, 16'h1234, 0, 0, -1, 0, 0, 0, "mode0 basic");
        check("mode0 rx_data", {16'd0, rx_data_w[0]}, 32'h1234);

        do_load(16'h0001);
        for (int m = 1; m < 4; m++) run_frame(m, 16'hFFFF, 0, 0, -1, 0, 0, 0, "mode n");

        exp_err.push_back(0);
        spi_frame(0, 16'hBEEF, 7, 0, 0, -1, 0, 0, 0, 0, dummy);
        check("err rx_data kept", {16'd0, rx_data_w[0]}, {16'd0, model_rx[0]});
        check("err back idle", {30'd0, state_w[0]}, 32'd0);
        run_frame(0, 16'hBEEF, 0, 0, -1, 0, 0, 0, "after err");

        run_frame(0, 16'h0F1E, 1, 16'h5555, -1, 0, 0, 0, "load at fall");
        run_frame(0, 16'h7788, 0, 0, -1, 0, 0, 0, "resend");

        run_frame(0, 16'hC0DE, 0, 0, -1, 0, 3, 0, "extra edges");

        run_frame(1, 16'h6A5F, 0, 0, -1, 0, 0, 1, "cs on last m1");
        run_frame(0, 16'h96A3, 0, 0, -1, 0, 0, 1, "cs on last m0");

        run_frame(2, 16'h2468, 0, 0, 4, 16'h1357, 0, 0, "load mid frame");
        run_frame(3, 16'h8421, 0, 0, -1, 0, 0, 0, "other got mid load");

        spi_frame(0, 16'hDEAD, 8, 0, 0, -1, 0, 0, 0, 1, dummy);
        @(negedge i_clk);
        i_rst = 1'b0;
        wait_n(3);
        i_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            model_buf[k] = '0;
            model_rx[k]  = '0;
        end
        check("midreset rx_data", {16'd0, rx_data_w[0]}, 32'd0);
        for (int b = 0; b < 8; b++) begin
            sclk[0] = 1'b1;
            wait_n(H);
            sclk[0] = 1'b0;
            wait_n(H);
        end
        check("midreset ignored", {30'd0, state_w[0]}, 32'd0);
        cs[0] = 1'b1;
        wait_n(3 * H);
        run_frame(0, 16'h3C96, 0, 0, -1, 0, 0, 0, "after reset");

        for (int n = 0; n < 14; n++) begin
            int          m, mid;
            logic [15:0] w, lv;
            bit          lf;
            m   = $urandom_range(0, 3);
            w   = 16'($urandom);
            lv  = 16'($urandom);
            if ($urandom_range(0, 1) == 1) do_load(16'($urandom));
            lf  = ($urandom_range(0, 3) == 0);
            mid = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : -1;
            run_frame(m, w, lf, lv, mid, 16'($urandom), 0, 0, "random");
        end

        wait_n(20);
        check("rx queue drained", exp_rx.size(), 0);
        check("err queue drained", exp_err.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bits per SPI frame, MSB first.
REQ-002 Parameter CPOL, default 1'b0: SCLK idle level.
REQ-003 Parameter CPHA, default 1'b0: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-004 i_clk  input  1  system clock; all logic on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_spi_clk  input  1  external SCLK, asynchronous to i_clk.
REQ-007 i_cs  input  1  external chip select, active-low, asynchronous.
REQ-008 i_mosi  input  1  external MOSI, asynchronous.
REQ-009 o_miso  output  1  MISO line; high-Z while synchronized CS is high.
REQ-010 i_tx_data  input  DATA_WIDTH  word to return on MISO.
REQ-011 i_tx_load  input  1  one-cycle strobe that captures i_tx_data into the TX buffer.
REQ-012 o_tx_ready  output  1  high in IDLE; the TX buffer may be loaded.
REQ-013 o_rx_data  output  DATA_WIDTH  last complete word received on MOSI.
REQ-014 o_rx_valid  output  1  one-cycle pulse; o_rx_data has been updated.
REQ-015 o_frame_err  output  1  one-cycle pulse; CS rose before DATA_WIDTH bits were sampled.
REQ-016 o_spi_state  output  2  current FSM state, for debug.

Function
REQ-017 SCLK, CS and MOSI SHALL each pass through a 2-FF synchronizer; edges SHALL be detected from the synchronized values against a registered copy.
REQ-018 Leading edge SHALL mean SCLK leaving the CPOL level; trailing edge SHALL mean SCLK returning to it.
REQ-019 FSM states SHALL be IDLE=0, SHIFT=1, DONE=2; encoding 3 is illegal and SHALL go to IDLE.
REQ-020 IDLE->SHIFT on synchronized CS falling; on that cycle tx_shift loads the TX buffer, and bit_cnt and rx_shift clear.
REQ-021 If i_tx_load occurs on the same cycle as the CS fall, tx_shift SHALL load i_tx_data directly.
REQ-022 i_tx_load SHALL be ignored outside IDLE; when no load occurred, the previous TX buffer value SHALL be resent.
REQ-023 CPHA=0: tx_shift MSB SHALL drive o_miso from SHIFT entry; each trailing edge SHALL shift tx_shift left, filling 0.
REQ-024 CPHA=1: the first leading edge SHALL NOT shift tx_shift; every later leading edge SHALL shift it.
REQ-025 Each sampling edge SHALL shift synchronized MOSI into rx_shift LSB and increment bit_cnt.
REQ-026 When bit_cnt reaches DATA_WIDTH, the next cycle SHALL write o_rx_data with the complete word, pulse o_rx_valid, and enter DONE.
REQ-027 o_rx_valid SHALL assert on the 4th i_clk rising edge after the raw sampling edge of the last bit, with setup met.
REQ-028 In DONE, SCLK edges SHALL be ignored and o_miso SHALL drive 0 while CS is low; DONE->IDLE on synchronized CS rising.
REQ-029 In SHIFT, CS rising with bit_cnt < DATA_WIDTH SHALL pulse o_frame_err, leave o_rx_data unchanged, and go to IDLE.
REQ-030 If CS rises on the same cycle as the final sampling edge, the word SHALL complete: o_rx_valid asserts, no o_frame_err, then IDLE.
REQ-031 SCLK half-period SHALL be at least 4 i_clk periods; faster SCLK is unsupported and behaviour is undefined.
REQ-032 o_tx_ready SHALL equal (state == IDLE).

Reset
REQ-033 On i_rst low: state=IDLE; o_rx_data, TX buffer, tx_shift, rx_shift and bit_cnt = 0; o_rx_valid and o_frame_err = 0.
REQ-034 On i_rst low: synchronizer flops = {SCLK: CPOL, CS: 1, MOSI: 0}; o_miso = high-Z.
REQ-035 Reset asserted mid-frame SHALL abort without o_rx_valid or o_frame_err.
REQ-036 After reset, a frame already in progress (CS low at release) SHALL be ignored until CS has been seen high.

Structure
REQ-037 A shared package spi_pkg SHALL hold the state encodings and the CPOL/CPHA mode constants, reused by the SPI master.
REQ-038 A single sub-module spi_sync (2-FF synchronizer with parameter reset value) SHALL be instantiated 3 times; all other logic SHALL be flat.

Verification
REQ-039 Mode 0, DATA_WIDTH=16, load 0xA5C3, master sends 0x1234 at SCLK = i_clk/8 -> o_rx_data=0x1234, one o_rx_valid pulse, master receives 0xA5C3.
REQ-040 Modes 1, 2 and 3, each exchanging 0xFFFF/0x0001 -> correct word in both directions for every mode.
REQ-041 CS raised after 7 bits -> one o_frame_err pulse, o_rx_data unchanged, then a full 0xBEEF frame is received correctly.
REQ-042 i_tx_load of 0x5555 on the CS-fall cycle -> MISO returns 0x5555; a second frame with no load -> 0x5555 again.
REQ-043 i_rst pulsed mid-frame with CS held low -> no valid/err pulses; the next CS-high-then-low frame is received correctly.
REQ-044 Extra SCLK edges after bit 16, before CS rises -> a single o_rx_valid pulse, o_miso=0, no o_frame_err.
